// File: rtl/ray_march_ctrl_pkg.sv
// Shared types and Q16.16 helpers for the ray-march controller.
package raymarch_pkg;

   typedef struct packed {
      logic signed [31:0] x;
      logic signed [31:0] y;
      logic signed [31:0] z;
   } vec3_t;

   localparam logic signed [31:0] FIX_ONE = 32'sh0001_0000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CALC  = 3'd1,
      ST_QUERY = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Full 64-bit signed product, keep the Q16.16 window (truncating).
   function automatic logic signed [31:0] fix_mul(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
      logic signed [63:0] w_p;
      w_p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return w_p[47:16];
   endfunction

endpackage

// File: rtl/ray_march_ctrl_if.sv
// Ray input, scene query/response and result channels of the ray-march controller.
interface ray_march_ctrl_if;
   import raymarch_pkg::*;

   logic               ray_valid;
   logic               ray_ready;
   vec3_t              ray_origin;
   vec3_t              ray_dir;
   logic               q_valid;
   logic               q_ready;
   vec3_t              q_pos;
   logic               d_valid;
   logic signed [31:0] d_dist;
   logic               res_valid;
   logic               res_ready;
   logic               res_hit;
   logic [31:0]        res_t;
   logic [7:0]         res_steps;

   // master = the controller, slave = ray source / scene / result sink
   modport master (
      input  ray_valid, ray_origin, ray_dir, q_ready, d_valid, d_dist, res_ready,
      output ray_ready, q_valid, q_pos, res_valid, res_hit, res_t, res_steps
   );

   modport slave (
      output ray_valid, ray_origin, ray_dir, q_ready, d_valid, d_dist, res_ready,
      input  ray_ready, q_valid, q_pos, res_valid, res_hit, res_t, res_steps
   );

endinterface

// File: rtl/ray_march_ctrl_point_eval.sv
// Combinational point along a ray: pos = origin + t*dir, per component, wrapping add.
module ray_point_eval
   import raymarch_pkg::*;
(
   input  vec3_t              i_origin,
   input  vec3_t              i_dir,
   input  logic signed [31:0] i_t,
   output vec3_t              o_pos
);

   assign o_pos.x = i_origin.x + fix_mul(i_t, i_dir.x);
   assign o_pos.y = i_origin.y + fix_mul(i_t, i_dir.y);
   assign o_pos.z = i_origin.z + fix_mul(i_t, i_dir.z);

endmodule

// File: rtl/ray_march_ctrl.sv
// Sequential ray-march initiator: queries the scene SDF and advances t until hit/miss/step limit.
// Build option RAYMARCH_RELAX_EN: advance by 0.875*d instead of d (hit test unchanged).
module ray_march_ctrl
   import raymarch_pkg::*;
#(
   parameter int                 MAX_STEPS = 64,
   parameter logic signed [31:0] EPSILON   = 32'sh0000_0041,
   parameter logic signed [31:0] MAX_T     = 32'sh0064_0000
)(
   input  logic              clk,
   input  logic              rst_n,
   ray_march_ctrl_if.master  bus
);

   // state | meaning
   // IDLE  | ready for a new ray
   // CALC  | register origin + t*dir into the query position
   // QUERY | q_valid high, waiting for q_ready
   // WAIT  | waiting for the d_valid pulse
   // DONE  | result presented until res_ready

   localparam logic [7:0] LP_MAX_STEPS = 8'(MAX_STEPS);

   state_t             r_state, w_state_nxt;
   vec3_t              r_origin, r_dir, r_pos;
   logic signed [31:0] r_t;
   logic [7:0]         r_steps;
   logic               r_hit;

   vec3_t              w_pos;
   logic signed [31:0] w_adv;
   logic signed [32:0] w_sum;
   logic signed [31:0] w_t_next;
   logic [7:0]         w_steps_inc;
   logic               w_is_hit, w_over, w_limit, w_finish;

   ray_point_eval u_point_eval (
      .i_origin (r_origin),
      .i_dir    (r_dir),
      .i_t      (r_t),
      .o_pos    (w_pos)
   );

`ifdef RAYMARCH_RELAX_EN
   assign w_adv = bus.d_dist - (bus.d_dist >>> 3);
`else
   assign w_adv = bus.d_dist;
`endif

   // t never goes negative, so only positive overflow needs clamping
   assign w_sum       = $signed({r_t[31], r_t}) + $signed({w_adv[31], w_adv});
   assign w_t_next    = (w_sum > 33'sh0_7FFF_FFFF) ? 32'sh7FFF_FFFF : w_sum[31:0];
   assign w_steps_inc = r_steps + 8'd1;
   assign w_is_hit    = bus.d_dist < EPSILON;
   assign w_over      = w_t_next > MAX_T;
   assign w_limit     = w_steps_inc == LP_MAX_STEPS;
   assign w_finish    = w_is_hit | w_over | w_limit;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.ray_valid) w_state_nxt = ST_CALC;
         ST_CALC:  w_state_nxt = ST_QUERY;
         ST_QUERY: if (bus.q_ready) w_state_nxt = ST_WAIT;
         ST_WAIT:  if (bus.d_valid) w_state_nxt = w_finish ? ST_DONE : ST_CALC;
         ST_DONE:  if (bus.res_ready) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_origin <= '0;
         r_dir    <= '0;
         r_pos    <= '0;
         r_t      <= '0;
         r_steps  <= '0;
         r_hit    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.ray_valid) begin
                  r_origin <= bus.ray_origin;
                  r_dir    <= bus.ray_dir;
                  r_t      <= '0;
                  r_steps  <= '0;
                  r_hit    <= 1'b0;
               end
            end
            ST_CALC: r_pos <= w_pos;
            ST_WAIT: begin
               if (bus.d_valid) begin
                  r_steps <= w_steps_inc;
                  if (w_is_hit) r_hit <= 1'b1;
                  else          r_t   <= w_t_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ray_ready = (r_state == ST_IDLE);
   assign bus.q_valid   = (r_state == ST_QUERY);
   assign bus.q_pos     = r_pos;
   assign bus.res_valid = (r_state == ST_DONE);
   assign bus.res_hit   = r_hit;
   assign bus.res_t     = r_t;
   assign bus.res_steps = r_steps;

endmodule

// File: tb/tb_ray_march_ctrl.sv
// Directed bench for ray_march_ctrl with a 1-cycle plane / constant-distance scene model.
module tb_ray_march_ctrl;
   import raymarch_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ray_march_ctrl_if bus ();

   ray_march_ctrl #(.MAX_STEPS(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] pos_z[$];
   logic        got_hit;
   logic [31:0] got_t;
   logic [7:0]  got_steps;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // 0: plane z=5 (d = 5 - z), 1: constant 0.5, other: constant -0.25
   function automatic logic [31:0] scene(input int mode, input logic [31:0] z);
      case (mode)
         0:       return 32'h0005_0000 - z;
         1:       return 32'h0000_8000;
         default: return 32'hFFFF_C000;
      endcase
   endfunction

   task automatic run_ray(input logic [31:0] dz, input int mode, input int qhold, input int rhold);
      int          cyc;
      logic        done;
      logic [95:0] held;
      logic [40:0] res_snap;
      pos_z.delete();
      bus.ray_origin = '0;
      bus.ray_dir    = {32'h0, 32'h0, dz};
      bus.ray_valid  = 1'b1;
      tick();
      bus.ray_valid  = 1'b0;
      chk("ray_ready_busy", 96'(bus.ray_ready), 96'(0));
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 2000) begin
         if (bus.res_valid) begin
            done = 1'b1;
         end else if (bus.q_valid) begin
            pos_z.push_back(bus.q_pos.z);
            if (qhold > 0 && pos_z.size() == 1) begin
               held = bus.q_pos;
               for (int i = 0; i < qhold; i++) begin
                  tick();
                  cyc++;
                  chk("q_hold_valid", 96'(bus.q_valid), 96'(1));
                  chk("q_hold_pos", bus.q_pos, held);
               end
            end
            bus.q_ready = 1'b1;
            tick();
            cyc++;
            bus.q_ready = 1'b0;
            bus.d_valid = 1'b1;
            bus.d_dist  = scene(mode, pos_z[pos_z.size()-1]);
            tick();
            cyc++;
            bus.d_valid = 1'b0;
         end else begin
            tick();
            cyc++;
         end
      end
      n_tests++;
      assert (done) else begin
         n_fail++;
         $error("FAIL result_timeout observed=%0d cycles expected=res_valid", cyc);
      end
      got_hit   = bus.res_hit;
      got_t     = bus.res_t;
      got_steps = bus.res_steps;
      res_snap  = {bus.res_hit, bus.res_t, bus.res_steps};
      for (int i = 0; i < rhold; i++) begin
         tick();
         chk("r_hold_valid", 96'(bus.res_valid), 96'(1));
         chk("r_hold_ray_ready", 96'(bus.ray_ready), 96'(0));
         chk("r_hold_fields", 96'({bus.res_hit, bus.res_t, bus.res_steps}), 96'(res_snap));
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk("back_to_idle", 96'(bus.ray_ready), 96'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ray_ready"}, 96'(bus.ray_ready), 96'(1));
      chk({tag, "_q_valid"},   96'(bus.q_valid),   96'(0));
      chk({tag, "_res_valid"}, 96'(bus.res_valid), 96'(0));
      chk({tag, "_res_hit"},   96'(bus.res_hit),   96'(0));
      chk({tag, "_res_t"},     96'(bus.res_t),     96'(0));
      chk({tag, "_res_steps"}, 96'(bus.res_steps), 96'(0));
      chk({tag, "_q_pos"},     bus.q_pos,          96'(0));
   endtask

   task automatic wait_query(input string tag);
      int i;
      i = 0;
      while (!bus.q_valid && i < 20) begin
         tick();
         i++;
      end
      chk(tag, 96'(bus.q_valid), 96'(1));
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.ray_valid = 1'b0;
      bus.ray_origin = '0;
      bus.ray_dir   = '0;
      bus.q_ready   = 1'b0;
      bus.d_valid   = 1'b0;
      bus.d_dist    = '0;
      bus.res_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_reset_outputs("reset");

      // plane ahead, query held off for 7 cycles
      run_ray(FIX_ONE, 0, 7, 0);
      chk("plane_fwd_hit", 96'(got_hit), 96'(1));
      chk("plane_fwd_pos0", 96'(pos_z[0]), 96'(32'h0000_0000));
`ifdef RAYMARCH_RELAX_EN
      chk("plane_fwd_pos1", 96'(pos_z[1]), 96'(32'h0004_6000));
`else
      chk("plane_fwd_pos1", 96'(pos_z[1]), 96'(32'h0005_0000));
      chk("plane_fwd_t", 96'(got_t), 96'(32'h0005_0000));
      chk("plane_fwd_steps", 96'(got_steps), 96'(8'd2));
`endif

      // plane behind: t grows past MAX_T, result held off for 10 cycles
      run_ray(32'hFFFF_0000, 0, 0, 10);
      chk("plane_back_hit", 96'(got_hit), 96'(0));
      chk("plane_back_steps", 96'(got_steps), 96'(8'd5));
`ifndef RAYMARCH_RELAX_EN
      chk("plane_back_t", 96'(got_t), 96'(32'h009B_0000));
      chk("plane_back_pos4", 96'(pos_z[4]), 96'(32'hFFB5_0000));
`endif

      // constant 0.5 -> step limit
      run_ray(FIX_ONE, 1, 0, 0);
      chk("limit_hit", 96'(got_hit), 96'(0));
      chk("limit_steps", 96'(got_steps), 96'(8'd64));
`ifdef RAYMARCH_RELAX_EN
      chk("limit_t", 96'(got_t), 96'(32'h001C_0000));
`else
      chk("limit_t", 96'(got_t), 96'(32'h0020_0000));
`endif

      // negative distance on first query -> immediate hit
      run_ray(FIX_ONE, 2, 0, 0);
      chk("inside_hit", 96'(got_hit), 96'(1));
      chk("inside_t", 96'(got_t), 96'(0));
      chk("inside_steps", 96'(got_steps), 96'(8'd1));

      // reset while waiting on the second distance, then a stray d_valid
      bus.ray_origin = '0;
      bus.ray_dir    = {32'h0, 32'h0, FIX_ONE};
      bus.ray_valid  = 1'b1;
      tick();
      bus.ray_valid  = 1'b0;
      wait_query("rst_query1");
      bus.q_ready = 1'b1;
      tick();
      bus.q_ready = 1'b0;
      bus.d_valid = 1'b1;
      bus.d_dist  = 32'h0005_0000;
      tick();
      bus.d_valid = 1'b0;
      wait_query("rst_query2");
      bus.q_ready = 1'b1;
      tick();
      bus.q_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.d_valid = 1'b1;
      bus.d_dist  = 32'hFFFF_C000;
      tick();
      bus.d_valid = 1'b0;
      check_reset_outputs("midrst");
      for (int i = 0; i < 5; i++) tick();
      chk("midrst_no_result", 96'(bus.res_valid), 96'(0));
      chk("midrst_idle", 96'(bus.ray_ready), 96'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
